// File: rtl/jtag_pkg.sv
// Shared definitions for the jtag shift engine and its transaction scheduler.
// The TAP constants are consumed by the engine; the scheduler uses the state enum and DR_WORDS.
package jtag_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD_IR,
    S_LOAD_DR,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } sched_state_e;

  localparam int DR_WORDS = 4;

  localparam logic [3:0] RESET_TAP   = 4'h0;
  localparam logic [3:0] GO_SHIFT_IR = 4'h1;
  localparam logic [3:0] GO_SHIFT_DR = 4'h2;
  localparam logic [3:0] GO_EXIT     = 4'h3;

  // TCK = clk / TCK_DIV
  localparam int TCK_DIV = 4;

endpackage

// File: rtl/jtag_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester.
// The pointer only moves when the grant is actually taken.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     update,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update && found) begin
      ptr <= (idx == IDX_W'(N_REQ-1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/jtag_scheduler.sv
// Arbitrates whole IR/DR transactions from N_REQ requesters, loads the jtag
// engine FIFOs, launches the engine and reports per-requester ack or err.
module jtag_scheduler #(
  parameter int N_REQ            = 2,
  parameter int DATA_INSTRUCTION = 6,
  parameter int DATA_FIFO        = 8,
  parameter int DR_WORDS         = jtag_pkg::DR_WORDS,
  parameter int BUSY_TIMEOUT     = 15
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ-1:0]                  req_op,
  input  logic [N_REQ*DATA_INSTRUCTION-1:0] req_instr,
  input  logic [N_REQ*DATA_FIFO*DR_WORDS-1:0] req_data,
  output logic [N_REQ-1:0]                  ack,
  output logic [N_REQ-1:0]                  err,
  output logic                              op,
  output logic                              work,
  input  logic                              busy,
  output logic                              wr_instruction,
  output logic [DATA_INSTRUCTION-1:0]       wdata_instruction,
  input  logic                              full_instruction,
  output logic                              wr_data,
  output logic [DATA_FIFO-1:0]              wdata_data,
  input  logic                              full_data,
  output logic                              sched_busy
);

  import jtag_pkg::*;

  // state       | meaning
  // S_INIT      | engine running TAP reset, wait for busy=0
  // S_IDLE      | accept next grant
  // S_LOAD_IR   | write latched instruction into instruction FIFO
  // S_LOAD_DR   | write DR_WORDS data words, most significant first
  // S_START     | one-cycle work pulse
  // S_WAIT_BUSY | wait for engine to start, bounded by BUSY_TIMEOUT
  // S_WAIT_DONE | wait for engine to finish, no bound

  localparam int DR_W  = DATA_FIFO * DR_WORDS;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DR_WORDS + 1);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

  sched_state_e state, state_nxt;

  logic [IDX_W-1:0]            idx_q, idx_nxt;
  logic                        op_lat, op_lat_nxt;
  logic [DR_W-1:0]             data_q, data_nxt;
  logic [CNT_W-1:0]            cnt_q, cnt_nxt;
  logic [TMO_W-1:0]            tmo_q, tmo_nxt;

  logic [N_REQ-1:0]            ack_q, ack_nxt;
  logic [N_REQ-1:0]            err_q, err_nxt;
  logic                        op_q, op_nxt;
  logic                        work_q, work_nxt;
  logic                        wr_ins_q, wr_ins_nxt;
  logic [DATA_INSTRUCTION-1:0] wdata_ins_q, wdata_ins_nxt;
  logic                        wr_dat_q, wr_dat_nxt;
  logic [DATA_FIFO-1:0]        wdata_dat_q, wdata_dat_nxt;
  logic                        sched_busy_q, sched_busy_nxt;

  logic [N_REQ-1:0]            grant;
  logic [IDX_W-1:0]            grant_idx;
  logic                        take;
  logic                        win_op;
  logic [DATA_INSTRUCTION-1:0] win_instr;
  logic [DR_W-1:0]             win_data;
  logic [DR_W-1:0]             shifted;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .update (take),
    .grant  (grant),
    .idx    (grant_idx)
  );

  always_comb begin
    win_op    = 1'b0;
    win_instr = '0;
    win_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_op    = win_op | req_op[i];
        win_instr = win_instr | req_instr[i*DATA_INSTRUCTION +: DATA_INSTRUCTION];
        win_data  = win_data | req_data[i*DR_W +: DR_W];
      end
    end
  end

  assign shifted = data_q << (DATA_FIFO * int'(cnt_q));

  // Output registers are loaded from next-state decode, so FIFO full is sampled
  // one cycle ahead of the write strobe it gates.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx_q;
    op_lat_nxt    = op_lat;
    data_nxt      = data_q;
    cnt_nxt       = cnt_q;
    tmo_nxt       = tmo_q;
    ack_nxt       = '0;
    err_nxt       = '0;
    op_nxt        = op_q;
    work_nxt      = 1'b0;
    wr_ins_nxt    = 1'b0;
    wdata_ins_nxt = wdata_ins_q;
    wr_dat_nxt    = 1'b0;
    wdata_dat_nxt = wdata_dat_q;
    take          = 1'b0;

    case (state)
      S_INIT: begin
        if (!busy) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        // requesters still hold req during the ack cycle
        if ((|req) && !(|ack_q)) begin
          take          = 1'b1;
          idx_nxt       = grant_idx;
          op_lat_nxt    = win_op;
          data_nxt      = win_data;
          wdata_ins_nxt = win_instr;
          if (win_op) begin
            state_nxt     = S_LOAD_DR;
            wr_dat_nxt    = !full_data;
            wdata_dat_nxt = win_data[DR_W-1 -: DATA_FIFO];
            cnt_nxt       = full_data ? '0 : CNT_W'(1);
          end else begin
            state_nxt  = S_LOAD_IR;
            wr_ins_nxt = !full_instruction;
          end
        end
      end
      S_LOAD_IR: begin
        if (wr_ins_q) begin
          state_nxt = S_START;
          work_nxt  = 1'b1;
          op_nxt    = op_lat;
          tmo_nxt   = TMO_W'(BUSY_TIMEOUT - 1);
        end else begin
          wr_ins_nxt = !full_instruction;
        end
      end
      S_LOAD_DR: begin
        if (cnt_q == CNT_W'(DR_WORDS)) begin
          state_nxt = S_START;
          work_nxt  = 1'b1;
          op_nxt    = op_lat;
          tmo_nxt   = TMO_W'(BUSY_TIMEOUT - 1);
        end else begin
          wr_dat_nxt    = !full_data;
          wdata_dat_nxt = shifted[DR_W-1 -: DATA_FIFO];
          if (!full_data) cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_START: begin
        state_nxt = S_WAIT_BUSY;
        if (tmo_q != '0) tmo_nxt = tmo_q - 1'b1;
      end
      S_WAIT_BUSY: begin
        if (busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (tmo_q == '0) begin
          err_nxt[idx_q] = 1'b1;
          state_nxt      = S_INIT;
        end else begin
          tmo_nxt = tmo_q - 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!busy) begin
          ack_nxt[idx_q] = 1'b1;
          state_nxt      = S_IDLE;
        end
      end
      default: state_nxt = S_INIT;
    endcase

    sched_busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT;
      idx_q        <= '0;
      op_lat       <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      op_q         <= 1'b0;
      work_q       <= 1'b0;
      wr_ins_q     <= 1'b0;
      wdata_ins_q  <= '0;
      wr_dat_q     <= 1'b0;
      wdata_dat_q  <= '0;
      sched_busy_q <= 1'b1;
    end else begin
      state        <= state_nxt;
      idx_q        <= idx_nxt;
      op_lat       <= op_lat_nxt;
      data_q       <= data_nxt;
      cnt_q        <= cnt_nxt;
      tmo_q        <= tmo_nxt;
      ack_q        <= ack_nxt;
      err_q        <= err_nxt;
      op_q         <= op_nxt;
      work_q       <= work_nxt;
      wr_ins_q     <= wr_ins_nxt;
      wdata_ins_q  <= wdata_ins_nxt;
      wr_dat_q     <= wr_dat_nxt;
      wdata_dat_q  <= wdata_dat_nxt;
      sched_busy_q <= sched_busy_nxt;
    end
  end

  assign ack               = ack_q;
  assign err               = err_q;
  assign op                = op_q;
  assign work              = work_q;
  assign wr_instruction    = wr_ins_q;
  assign wdata_instruction = wdata_ins_q;
  assign wr_data           = wr_dat_q;
  assign wdata_data        = wdata_dat_q;
  assign sched_busy        = sched_busy_q;

endmodule

// File: tb/tb_jtag_scheduler.sv
// Self-checking bench for jtag_scheduler: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_jtag_scheduler;

  localparam int N_REQ = 2;
  localparam int DI    = 6;
  localparam int DF    = 8;
  localparam int DRW   = 4;
  localparam int BT    = 15;
  localparam int DRB   = DF * DRW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [N_REQ-1:0]      req = '0;
  logic [N_REQ-1:0]      req_op = '0;
  logic [N_REQ*DI-1:0]   req_instr = '0;
  logic [N_REQ*DRB-1:0]  req_data = '0;
  logic [N_REQ-1:0]      ack, err;
  logic                  op, work;
  logic                  busy = 1'b1;
  logic                  wr_instruction;
  logic [DI-1:0]         wdata_instruction;
  logic                  full_instruction = 1'b0;
  logic                  wr_data;
  logic [DF-1:0]         wdata_data;
  logic                  full_data = 1'b0;
  logic                  sched_busy;

  int vectors = 0;
  int miscompares = 0;
  int rr_next = 0;

  typedef struct {
    int               work_c;
    logic             op_w;
    int               first_wr;
    logic [N_REQ-1:0] ack_o;
    logic [N_REQ-1:0] err_o;
    int               done_c;
    int               n_ir;
    logic [DI-1:0]    ir_v;
    int               n_dr;
    logic [DRB-1:0]   dr_v;
    bit               op_ok;
  } obs_t;

  always #5 clk = ~clk;

  jtag_scheduler #(
    .N_REQ(N_REQ), .DATA_INSTRUCTION(DI), .DATA_FIFO(DF), .DR_WORDS(DRW), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_instr(req_instr),
    .req_data(req_data), .ack(ack), .err(err), .op(op), .work(work), .busy(busy),
    .wr_instruction(wr_instruction), .wdata_instruction(wdata_instruction),
    .full_instruction(full_instruction), .wr_data(wr_data), .wdata_data(wdata_data),
    .full_data(full_data), .sched_busy(sched_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference arbitration: first requester at or after rr_next, cyclically
  function automatic int pick(input logic [N_REQ-1:0] r);
    for (int i = 0; i < N_REQ; i++)
      if (r[(rr_next + i) % N_REQ]) return (rr_next + i) % N_REQ;
    return -1;
  endfunction

  // Called at the start of cycle 0 (request visible). Models the FIFOs' full
  // flags (high in cycles fs..fs+fl-1) and an engine that raises busy d cycles
  // after work for len cycles. Returns one cycle after ack/err.
  task automatic serve(input int fs, input int fl, input int d, input int len,
                       input bit drop, output obs_t ob);
    int c;
    bit fin;
    c = 0;
    fin = 1'b0;
    ob.work_c = -1; ob.op_w = 1'b0; ob.first_wr = -1; ob.ack_o = '0; ob.err_o = '0;
    ob.done_c = -1; ob.n_ir = 0; ob.ir_v = '0; ob.n_dr = 0; ob.dr_v = '0; ob.op_ok = 1'b1;
    full_instruction = (fs <= 0 && 0 < fs + fl);
    full_data        = full_instruction;
    while (!fin && c < 400) begin
      tick();
      c++;
      if (wr_instruction) begin
        ob.n_ir++;
        ob.ir_v = wdata_instruction;
        if (ob.first_wr < 0) ob.first_wr = c;
      end
      if (wr_data) begin
        ob.n_dr++;
        ob.dr_v = {ob.dr_v[DRB-DF-1:0], wdata_data};
        if (ob.first_wr < 0) ob.first_wr = c;
      end
      if (work && ob.work_c < 0) begin
        ob.work_c = c;
        ob.op_w   = op;
      end
      if (ob.work_c >= 0 && op !== ob.op_w) ob.op_ok = 1'b0;
      if (ack !== '0 || err !== '0) begin
        ob.ack_o  = ack;
        ob.err_o  = err;
        ob.done_c = c;
        fin = 1'b1;
        if (drop) req = '0;
      end
      if (ob.work_c >= 0)
        busy = (c >= ob.work_c + d) && (c < ob.work_c + d + len);
      full_instruction = (c >= fs && c < fs + fl);
      full_data        = full_instruction;
    end
    busy = 1'b0;
    full_instruction = 1'b0;
    full_data = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    obs_t ob;
    busy = 1'b1;
    #1 rst_n = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) rst_n = 1'b1;
      tick();
      vectors++;
      if ({ack, err, op, work, wr_instruction, wr_data, wdata_instruction, wdata_data} !== '0 ||
          sched_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: ack=%b err=%b op=%b work=%b wr_i=%b wr_d=%b wdi=%h wdd=%h sched_busy=%b, expected all 0 and sched_busy=1",
                 c, ack, err, op, work, wr_instruction, wr_data, wdata_instruction, wdata_data, sched_busy);
      end
    end
    rr_next = 0;
    req_op = '0;
    req_instr[0 +: DI] = 6'h2A;
    req = 2'b01;
    busy = 1'b0;
    rr_next = 1;
    serve(0, 0, 3, 4, 1'b1, ob);
    vectors++;
    if (ob.first_wr !== 2 || ob.work_c !== 3) begin
      miscompares++;
      $display("FAIL first_grant_after_init: write cycle %0d work cycle %0d, expected 2 and 3", ob.first_wr, ob.work_c);
    end
    vectors++;
    if (ob.ack_o !== 2'b01 || ob.ir_v !== 6'h2A) begin
      miscompares++;
      $display("FAIL first_grant_result: ack=%b instr=%h, expected 01 and 2a", ob.ack_o, ob.ir_v);
    end
  endtask

  task automatic test_ir();
    obs_t ob;
    req_op = '0;
    req_instr[0 +: DI] = 6'h2A;
    req = 2'b01;
    rr_next = 1;
    serve(0, 0, 2, 40, 1'b1, ob);
    vectors++;
    if (ob.first_wr !== 1 || ob.n_ir !== 1 || ob.ir_v !== 6'h2A) begin
      miscompares++;
      $display("FAIL ir_write: cycle %0d count %0d value %h, expected cycle 1 count 1 value 2a", ob.first_wr, ob.n_ir, ob.ir_v);
    end
    vectors++;
    if (ob.work_c !== 2 || ob.op_w !== 1'b0 || !ob.op_ok) begin
      miscompares++;
      $display("FAIL ir_work: cycle %0d op %b stable %0d, expected cycle 2 op 0 stable 1", ob.work_c, ob.op_w, ob.op_ok);
    end
    vectors++;
    if (ob.ack_o !== 2'b01 || ob.err_o !== 2'b00 || ob.done_c !== 45) begin
      miscompares++;
      $display("FAIL ir_ack: ack=%b err=%b cycle %0d, expected 01 00 cycle 45", ob.ack_o, ob.err_o, ob.done_c);
    end
    vectors++;
    if (ob.n_dr !== 0 || ack !== 2'b00) begin
      miscompares++;
      $display("FAIL ir_side_effects: wr_data count %0d, ack after pulse %b, expected 0 and 00", ob.n_dr, ack);
    end
  endtask

  task automatic test_dr_backpressure();
    obs_t ob;
    req_op = 2'b10;
    req_data[DRB +: DRB] = 32'hDEADBEEF;
    req = 2'b10;
    rr_next = 0;
    serve(2, 3, 3, 10, 1'b1, ob);
    vectors++;
    if (ob.n_dr !== 4 || ob.dr_v !== 32'hDEADBEEF || ob.n_ir !== 0) begin
      miscompares++;
      $display("FAIL dr_words: count %0d data %h ir writes %0d, expected 4 deadbeef 0", ob.n_dr, ob.dr_v, ob.n_ir);
    end
    vectors++;
    if (ob.work_c !== 8 || ob.op_w !== 1'b1 || !ob.op_ok) begin
      miscompares++;
      $display("FAIL dr_work: cycle %0d op %b stable %0d, expected cycle 8 op 1 stable 1", ob.work_c, ob.op_w, ob.op_ok);
    end
    vectors++;
    if (ob.ack_o !== 2'b10 || ob.done_c !== 8 + 3 + 10 + 1) begin
      miscompares++;
      $display("FAIL dr_ack: ack=%b cycle %0d, expected 10 cycle %0d", ob.ack_o, ob.done_c, 22);
    end
  endtask

  task automatic test_round_robin();
    obs_t ob;
    int win;
    req_op = '0;
    req_instr = {6'h15, 6'h0A};
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      win = pick(2'b11);
      rr_next = (win + 1) % N_REQ;
      serve(0, 0, 2, 3, k == 3, ob);
      vectors++;
      if (ob.ack_o !== N_REQ'(1 << win) || ob.ir_v !== req_instr[win*DI +: DI] || ob.work_c !== 2) begin
        miscompares++;
        $display("FAIL rr_grant %0d: ack=%b instr=%h work %0d, expected ack for %0d instr %h work 2",
                 k, ob.ack_o, ob.ir_v, ob.work_c, win, req_instr[win*DI +: DI]);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t ob;
    req_op = '0;
    req_instr[0 +: DI] = DI'($urandom);
    req = 2'b01;
    rr_next = 1;
    serve(0, 0, 1000, 1, 1'b1, ob);
    vectors++;
    if (ob.err_o !== 2'b01 || ob.ack_o !== 2'b00 || ob.done_c !== ob.work_c + BT || ob.work_c !== 2) begin
      miscompares++;
      $display("FAIL timeout_err: err=%b ack=%b work %0d err cycle %0d, expected err 01 ack 00 work 2 err cycle %0d",
               ob.err_o, ob.ack_o, ob.work_c, ob.done_c, 2 + BT);
    end
    req_op = 2'b10;
    req_data[DRB +: DRB] = DRB'($urandom);
    req = 2'b10;
    rr_next = 0;
    serve(0, 0, 4, 6, 1'b1, ob);
    vectors++;
    if (ob.ack_o !== 2'b10 || ob.dr_v !== req_data[DRB +: DRB] || ob.done_c !== 5 + 4 + 6 + 1) begin
      miscompares++;
      $display("FAIL timeout_recover: ack=%b data %h cycle %0d, expected 10 %h cycle 16",
               ob.ack_o, ob.dr_v, ob.done_c, req_data[DRB +: DRB]);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    req_op = 2'b10;
    req_data[DRB +: DRB] = DRB'($urandom);
    req = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (work) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL abort_work: work not seen within 40 cycles, expected at cycle 5");
    end
    busy = 1'b1;
    tick();
    tick();
    tick();
    vectors++;
    if (op !== 1'b1 || sched_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: op=%b sched_busy=%b, expected 1 1", op, sched_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ack, err, op, work, wr_instruction, wr_data, wdata_instruction, wdata_data} !== '0 ||
        sched_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_async_clear: ack=%b err=%b op=%b work=%b wr_i=%b wr_d=%b sched_busy=%b, expected all 0 and sched_busy=1",
               ack, err, op, work, wr_instruction, wr_data, sched_busy);
    end
    req = '0;
    busy = 1'b0;
    tick();
    rst_n = 1'b1;
    rr_next = 0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack !== '0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_no_ack: ack seen after aborted transaction, expected none");
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [N_REQ-1:0] r;
      int win, fs, fl, d, len, exp_work, exp_done;
      logic o;
      obs_t ob;
      r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      req_op = N_REQ'($urandom);
      req_instr = (N_REQ*DI)'($urandom);
      req_data = {$urandom, $urandom};
      win = pick(r);
      o = req_op[win];
      rr_next = (win + 1) % N_REQ;
      fl = $urandom_range(0, 3);
      fs = o ? $urandom_range(0, DRW - 1) : 0;
      d = $urandom_range(1, BT + 3);
      len = $urandom_range(1, 12);
      req = r;
      serve(fs, fl, d, len, 1'b1, ob);
      exp_work = (o ? DRW + 1 : 2) + fl;
      exp_done = (d < BT) ? exp_work + d + len + 1 : exp_work + BT;
      vectors++;
      if (ob.work_c !== exp_work || ob.op_w !== o || !ob.op_ok ||
          ob.first_wr !== 1 + ((fs == 0) ? fl : 0)) begin
        miscompares++;
        $display("FAIL rand_timing %0d: work %0d op %b stable %0d first write %0d, expected work %0d op %b stable 1 first write %0d",
                 t, ob.work_c, ob.op_w, ob.op_ok, ob.first_wr, exp_work, o, 1 + ((fs == 0) ? fl : 0));
      end
      vectors++;
      if (o ? (ob.n_dr !== DRW || ob.dr_v !== req_data[win*DRB +: DRB] || ob.n_ir !== 0)
            : (ob.n_ir !== 1 || ob.ir_v !== req_instr[win*DI +: DI] || ob.n_dr !== 0)) begin
        miscompares++;
        $display("FAIL rand_payload %0d: ir %0d/%h dr %0d/%h, expected requester %0d op %b ir %h dr %h",
                 t, ob.n_ir, ob.ir_v, ob.n_dr, ob.dr_v, win, o, req_instr[win*DI +: DI], req_data[win*DRB +: DRB]);
      end
      vectors++;
      if (ob.done_c !== exp_done ||
          ob.ack_o !== ((d < BT) ? N_REQ'(1 << win) : N_REQ'(0)) ||
          ob.err_o !== ((d < BT) ? N_REQ'(0) : N_REQ'(1 << win))) begin
        miscompares++;
        $display("FAIL rand_done %0d: ack=%b err=%b cycle %0d, expected requester %0d %s at cycle %0d",
                 t, ob.ack_o, ob.err_o, ob.done_c, win, (d < BT) ? "ack" : "err", exp_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ir();
    test_dr_backpressure();
    test_round_robin();
    test_timeout();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
